// File: rtl/cache_replacement_nway.sv
// Dual-port N-way victim selector (tree-PLRU or round-robin) with per-port fill FSM holding the victim.
// we/victim/busy register one cycle after start; clear one cycle after fill_done; no backpressure.
module cache_replacement_nway #(
  parameter int IDX_SIZE = 6,
  parameter int WAYS     = 4,
  parameter int POLICY   = 0,
  localparam int SETS    = 2**IDX_SIZE,
  localparam int WAY_W   = $clog2(WAYS)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                read_p1_i,
  input  logic                read_p2_i,
  input  logic                write_p1_i,
  input  logic                write_p2_i,
  input  logic [IDX_SIZE-1:0] idx_p1_i,
  input  logic [IDX_SIZE-1:0] idx_p2_i,
  input  logic [WAYS-1:0]     hit_p1_i,
  input  logic [WAYS-1:0]     hit_p2_i,
  input  logic [WAYS-1:0]     valid_p1_i,
  input  logic [WAYS-1:0]     valid_p2_i,
  input  logic                write_through_i,
  input  logic                ram_write_start_p1_i,
  input  logic                ram_write_start_p2_i,
  input  logic                fill_done_p1_i,
  input  logic                fill_done_p2_i,
  output logic [WAYS-1:0]     we_p1_o,
  output logic [WAYS-1:0]     we_p2_o,
  output logic [WAY_W-1:0]    victim_p1_o,
  output logic [WAY_W-1:0]    victim_p2_o,
  output logic                busy_p1_o,
  output logic                busy_p2_o
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] FILL = 1'b1;

  logic [WAYS-2:0]  plru [SETS];
  logic [WAY_W-1:0] rr   [SETS];
  logic [0:0]       state_p1, state_p2;

  function automatic logic [WAY_W-1:0] low_idx(input logic [WAYS-1:0] v);
    low_idx = '0;
    for (int i = WAYS - 1; i >= 0; i--)
      if (v[i]) low_idx = WAY_W'(i);
  endfunction

  // Heap-ordered tree: children of node n are 2n+1 (lower half) and 2n+2 (upper half).
  function automatic logic [WAY_W-1:0] plru_walk(input logic [WAYS-2:0] t);
    int   node;
    logic b;
    plru_walk = '0;
    node = 0;
    for (int l = 0; l < WAY_W; l++) begin
      b = 1'b0;
      for (int n = 0; n < WAYS - 1; n++)
        if (n == node) b = t[n];
      plru_walk[WAY_W-1-l] = b;
      node = 2 * node + (b ? 2 : 1);
    end
  endfunction

  function automatic logic [WAYS-2:0] path_mask(input logic [WAY_W-1:0] w);
    int node;
    path_mask = '0;
    node = 0;
    for (int l = 0; l < WAY_W; l++) begin
      for (int n = 0; n < WAYS - 1; n++)
        if (n == node) path_mask[n] = 1'b1;
      node = 2 * node + (w[WAY_W-1-l] ? 2 : 1);
    end
  endfunction

  function automatic logic [WAYS-2:0] path_val(input logic [WAY_W-1:0] w);
    int node;
    path_val = '0;
    node = 0;
    for (int l = 0; l < WAY_W; l++) begin
      for (int n = 0; n < WAYS - 1; n++)
        if (n == node) path_val[n] = ~w[WAY_W-1-l];
      node = 2 * node + (w[WAY_W-1-l] ? 2 : 1);
    end
  endfunction

  logic             start_p1, start_p2, rd_p1, rd_p2;
  logic [WAY_W-1:0] pol_p1, pol_p2, cand_p1, cand_p2, way_p1, way_p2;
  logic [WAY_W-1:0] rd_way_p1, rd_way_p2;
  logic [WAYS-2:0]  rd_mask_p1, rd_val_p1, rd_mask_p2, rd_val_p2;
  logic [WAYS-2:0]  fl_mask_p1, fl_val_p1, fl_mask_p2, fl_val_p2;

  always_comb begin
    start_p1 = (state_p1 == IDLE) && write_p1_i && ram_write_start_p1_i;
    start_p2 = (state_p2 == IDLE) && write_p2_i && ram_write_start_p2_i;
    rd_p1    = read_p1_i && (|hit_p1_i);
    rd_p2    = read_p2_i && (|hit_p2_i);

    pol_p1 = (POLICY == 1) ? rr[idx_p1_i] : plru_walk(plru[idx_p1_i]);
    pol_p2 = (POLICY == 1) ? rr[idx_p2_i] : plru_walk(plru[idx_p2_i]);

    if (write_through_i && write_p1_i && (|hit_p1_i)) cand_p1 = low_idx(hit_p1_i);
    else if (!(&valid_p1_i))                           cand_p1 = low_idx(~valid_p1_i);
    else                                               cand_p1 = pol_p1;

    if (write_through_i && write_p2_i && (|hit_p2_i)) cand_p2 = low_idx(hit_p2_i);
    else if (!(&valid_p2_i))                           cand_p2 = low_idx(~valid_p2_i);
    else                                               cand_p2 = pol_p2;

    way_p1 = cand_p1;
    // Port 1 owns the set on a same-index start; port 2 steps to the next way.
    if (start_p1 && start_p2 && (idx_p1_i == idx_p2_i) && (cand_p2 == cand_p1))
      way_p2 = cand_p1 + WAY_W'(1);
    else
      way_p2 = cand_p2;

    rd_way_p1  = low_idx(hit_p1_i);
    rd_way_p2  = low_idx(hit_p2_i);
    rd_mask_p1 = path_mask(rd_way_p1);
    rd_val_p1  = path_val(rd_way_p1);
    rd_mask_p2 = path_mask(rd_way_p2);
    rd_val_p2  = path_val(rd_way_p2);
    fl_mask_p1 = path_mask(way_p1);
    fl_val_p1  = path_val(way_p1);
    fl_mask_p2 = path_mask(way_p2);
    fl_val_p2  = path_val(way_p2);
  end

  // Bit-granular non-blocking writes: a later update only overrides the nodes it shares.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int s = 0; s < SETS; s++) begin
        plru[s] <= '0;
        rr[s]   <= '0;
      end
    end else begin
      for (int n = 0; n < WAYS - 1; n++)
        if (rd_p1 && rd_mask_p1[n]) plru[idx_p1_i][n] <= rd_val_p1[n];
      for (int n = 0; n < WAYS - 1; n++)
        if (start_p1 && fl_mask_p1[n]) plru[idx_p1_i][n] <= fl_val_p1[n];
      if (start_p1) rr[idx_p1_i] <= rr[idx_p1_i] + WAY_W'(1);
      for (int n = 0; n < WAYS - 1; n++)
        if (rd_p2 && rd_mask_p2[n]) plru[idx_p2_i][n] <= rd_val_p2[n];
      for (int n = 0; n < WAYS - 1; n++)
        if (start_p2 && fl_mask_p2[n]) plru[idx_p2_i][n] <= fl_val_p2[n];
      if (start_p2) rr[idx_p2_i] <= rr[idx_p2_i] + WAY_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_p1    <= IDLE;
      state_p2    <= IDLE;
      we_p1_o     <= '0;
      we_p2_o     <= '0;
      victim_p1_o <= '0;
      victim_p2_o <= '0;
    end else begin
      if (start_p1) begin
        state_p1    <= FILL;
        we_p1_o     <= WAYS'(1) << way_p1;
        victim_p1_o <= way_p1;
      end else if ((state_p1 == FILL) && fill_done_p1_i) begin
        state_p1 <= IDLE;
        we_p1_o  <= '0;
      end
      if (start_p2) begin
        state_p2    <= FILL;
        we_p2_o     <= WAYS'(1) << way_p2;
        victim_p2_o <= way_p2;
      end else if ((state_p2 == FILL) && fill_done_p2_i) begin
        state_p2 <= IDLE;
        we_p2_o  <= '0;
      end
    end
  end

  assign busy_p1_o = (state_p1 == FILL);
  assign busy_p2_o = (state_p2 == FILL);

endmodule

// File: tb/tb_cache_replacement_nway.sv
// Directed bench: a PLRU instance and a round-robin instance share all stimulus.
module tb_cache_replacement_nway;

  logic       clk_i, rst_ni;
  logic       read_p1, read_p2, write_p1, write_p2, wt;
  logic [5:0] idx_p1, idx_p2;
  logic [3:0] hit_p1, hit_p2, valid_p1, valid_p2;
  logic       start_p1, start_p2, done_p1, done_p2;

  logic [3:0] we1_a, we2_a, we1_b, we2_b;
  logic [1:0] vic1_a, vic2_a, vic1_b, vic2_b;
  logic       busy1_a, busy2_a, busy1_b, busy2_b;

  int n_tests = 0;
  int n_fail  = 0;

  cache_replacement_nway #(.IDX_SIZE(6), .WAYS(4), .POLICY(0)) u_plru (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .read_p1_i(read_p1), .read_p2_i(read_p2),
    .write_p1_i(write_p1), .write_p2_i(write_p2),
    .idx_p1_i(idx_p1), .idx_p2_i(idx_p2),
    .hit_p1_i(hit_p1), .hit_p2_i(hit_p2),
    .valid_p1_i(valid_p1), .valid_p2_i(valid_p2),
    .write_through_i(wt),
    .ram_write_start_p1_i(start_p1), .ram_write_start_p2_i(start_p2),
    .fill_done_p1_i(done_p1), .fill_done_p2_i(done_p2),
    .we_p1_o(we1_a), .we_p2_o(we2_a),
    .victim_p1_o(vic1_a), .victim_p2_o(vic2_a),
    .busy_p1_o(busy1_a), .busy_p2_o(busy2_a)
  );

  cache_replacement_nway #(.IDX_SIZE(6), .WAYS(4), .POLICY(1)) u_rr (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .read_p1_i(read_p1), .read_p2_i(read_p2),
    .write_p1_i(write_p1), .write_p2_i(write_p2),
    .idx_p1_i(idx_p1), .idx_p2_i(idx_p2),
    .hit_p1_i(hit_p1), .hit_p2_i(hit_p2),
    .valid_p1_i(valid_p1), .valid_p2_i(valid_p2),
    .write_through_i(wt),
    .ram_write_start_p1_i(start_p1), .ram_write_start_p2_i(start_p2),
    .fill_done_p1_i(done_p1), .fill_done_p2_i(done_p2),
    .we_p1_o(we1_b), .we_p2_o(we2_b),
    .victim_p1_o(vic1_b), .victim_p2_o(vic2_b),
    .busy_p1_o(busy1_b), .busy_p2_o(busy2_b)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear_inputs;
    read_p1 = 0; read_p2 = 0; write_p1 = 0; write_p2 = 0; wt = 0;
    idx_p1 = 0; idx_p2 = 0; hit_p1 = 0; hit_p2 = 0;
    valid_p1 = 4'hF; valid_p2 = 4'hF;
    start_p1 = 0; start_p2 = 0; done_p1 = 0; done_p2 = 0;
  endtask

  task automatic do_reset;
    clear_inputs();
    rst_ni = 0;
    repeat (2) tick();
    rst_ni = 1;
    tick();
  endtask

  // Full port-1 fill; rr selects which instance is checked.
  task automatic fill1(input string tag, input bit rr, input logic [5:0] idx,
                       input logic [3:0] valid, input logic [3:0] hit, input logic [1:0] exp);
    idx_p1 = idx; valid_p1 = valid; hit_p1 = hit;
    write_p1 = 1; start_p1 = 1;
    check({tag, "_we_pre"}, rr ? we1_b : we1_a, 4'h0);
    tick();
    write_p1 = 0; start_p1 = 0; hit_p1 = 0;
    check({tag, "_we"}, rr ? we1_b : we1_a, 4'b0001 << exp);
    check({tag, "_victim"}, rr ? vic1_b : vic1_a, exp);
    check({tag, "_busy"}, rr ? busy1_b : busy1_a, 1);
    done_p1 = 1;
    tick();
    done_p1 = 0;
    check({tag, "_we_clr"}, rr ? we1_b : we1_a, 4'h0);
    check({tag, "_busy_clr"}, rr ? busy1_b : busy1_a, 0);
  endtask

  task automatic read1(input logic [5:0] idx, input logic [3:0] hit);
    read_p1 = 1; idx_p1 = idx; hit_p1 = hit;
    tick();
    read_p1 = 0; hit_p1 = 0;
  endtask

  initial begin
    clear_inputs();
    rst_ni = 0;
    tick();
    check("rst_we1", we1_a, 0);
    check("rst_we2", we2_a, 0);
    check("rst_vic1", vic1_a, 0);
    check("rst_busy1", busy1_a, 0);
    check("rst_busy2", busy2_a, 0);
    check("rst_we1_rr", we1_b, 0);
    rst_ni = 1;
    tick();

    // fill_done while idle must be ignored
    done_p1 = 1;
    tick();
    done_p1 = 0;
    check("done_idle_busy", busy1_a, 0);
    check("done_idle_we", we1_a, 0);

    // PLRU order on a fully valid set
    fill1("plru0", 0, 6'd5, 4'hF, 4'h0, 2'd0);
    fill1("plru1", 0, 6'd5, 4'hF, 4'h0, 2'd2);
    fill1("plru2", 0, 6'd5, 4'hF, 4'h0, 2'd1);
    fill1("plru3", 0, 6'd5, 4'hF, 4'h0, 2'd3);

    // Read-hit protection
    do_reset();
    fill1("rh_a", 0, 6'd5, 4'hF, 4'h0, 2'd0);
    read1(6'd5, 4'b0001);
    fill1("rh_b", 0, 6'd5, 4'hF, 4'h0, 2'd2);
    fill1("rh_other", 0, 6'd6, 4'hF, 4'h0, 2'd0);
    read1(6'd5, 4'b0010);
    fill1("rh_c", 0, 6'd5, 4'hF, 4'h0, 2'd3);

    // Write-through hit beats the PLRU choice (which would be way 0 here)
    wt = 1;
    fill1("wt", 0, 6'd5, 4'hF, 4'b0100, 2'd2);
    wt = 0;

    // Invalid-first, then round-robin with wrap
    do_reset();
    fill1("inv", 1, 6'd8, 4'b0111, 4'h0, 2'd3);
    fill1("rr0", 1, 6'd9, 4'hF, 4'h0, 2'd0);
    fill1("rr1", 1, 6'd9, 4'hF, 4'h0, 2'd1);
    fill1("rr2", 1, 6'd9, 4'hF, 4'h0, 2'd2);
    fill1("rr3", 1, 6'd9, 4'hF, 4'h0, 2'd3);
    fill1("rr_wrap", 1, 6'd9, 4'hF, 4'h0, 2'd0);

    // Same-index collision
    do_reset();
    idx_p1 = 6'd3; idx_p2 = 6'd3;
    write_p1 = 1; write_p2 = 1; start_p1 = 1; start_p2 = 1;
    tick();
    write_p1 = 0; write_p2 = 0; start_p1 = 0; start_p2 = 0;
    check("col_we1", we1_a, 4'b0001);
    check("col_we2", we2_a, 4'b0010);
    check("col_vic2", vic2_a, 1);
    check("col_busy1", busy1_a, 1);
    check("col_busy2", busy2_a, 1);
    done_p1 = 1; done_p2 = 1;
    tick();
    done_p1 = 0; done_p2 = 0;
    check("col_clr2", we2_a, 0);

    // Hold during fill, then asynchronous reset mid-fill
    do_reset();
    idx_p1 = 6'd5; write_p1 = 1; start_p1 = 1;
    tick();
    idx_p1 = 6'd7; hit_p1 = 4'b1000; valid_p1 = 4'h0;
    tick();
    check("hold_we", we1_a, 4'b0001);
    check("hold_vic", vic1_a, 0);
    check("hold_busy", busy1_a, 1);
    write_p1 = 0; start_p1 = 0; hit_p1 = 0; valid_p1 = 4'hF;
    #2 rst_ni = 0;
    #1;
    check("arst_we", we1_a, 0);
    check("arst_busy", busy1_a, 0);
    tick();
    rst_ni = 1;
    tick();
    fill1("post_rst", 0, 6'd5, 4'hF, 4'h0, 2'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
